// File: rtl/pwm_audio_dac_pkg.sv
// Shared definitions for the PWM audio DAC: sample width agreed with the APU
// channel outputs, plus small helpers for the PWM period arithmetic.
package pwm_audio_dac_pkg;

  localparam int APU_SAMPLE_W = 9;

  // Last counter value before the wrap; the period is 2**width-1 clocks.
  function automatic int periodMax(input int width);
    return (2 ** width) - 2;
  endfunction

  function automatic int periodLen(input int width);
    return (2 ** width) - 1;
  endfunction

endpackage

// File: rtl/pwm_audio_dac_period_counter.sv
// Wrapping PWM period counter with enable hold, wrap detect and a registered
// period-start strobe.
module pwm_period_counter
  import pwm_audio_dac_pkg::*;
#(
  parameter int WIDTH = APU_SAMPLE_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o,
  output logic             period_stb_o
);

  localparam logic [WIDTH-1:0] MaxCount = WIDTH'(periodMax(WIDTH));

  logic [WIDTH-1:0] count_q, count_d;
  logic             stb_q, stb_d;
  logic             wrap;

  assign wrap = enable_i && (count_q == MaxCount);

  // Disabled holds the counter at 0 without a strobe, so re-enable starts a
  // fresh period silently just like the reset-state counter 0.
  always_comb begin
    count_d = count_q + 1'b1;
    if (!enable_i || wrap) begin
      count_d = '0;
    end
    stb_d = wrap;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      stb_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      stb_q   <= stb_d;
    end
  end

  assign count_o      = count_q;
  assign wrap_o       = wrap;
  assign period_stb_o = stb_q;

endmodule

// File: rtl/pwm_audio_dac.sv
// PWM audio DAC: one-entry shadow register filled over valid/ready, loaded into
// the active compare level at each period boundary, driving a registered PWM pin.
module pwm_audio_dac
  import pwm_audio_dac_pkg::*;
#(
  parameter int WIDTH = APU_SAMPLE_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_sample,
  input  logic             i_sample_valid,
  output logic             o_sample_ready,
  output logic             o_pwm,
  output logic             o_period_stb,
  output logic             o_underrun
);

  logic [WIDTH-1:0] count;
  logic             wrap;

  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             shadowFull_q, shadowFull_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pwm_q, pwm_d;
  logic             underrun_q, underrun_d;
  logic             accept;

  pwm_period_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .enable_i    (i_enable),
    .count_o     (count),
    .wrap_o      (wrap),
    .period_stb_o(o_period_stb)
  );

  // Ready depends only on flop state so the sender sees no valid->ready path.
  assign o_sample_ready = !shadowFull_q;
  assign accept         = i_sample_valid && !shadowFull_q;

  // A wrap only drains a full shadow, and a full shadow cannot accept, so the
  // load and the transfer never compete; a sample arriving on an empty-shadow
  // wrap waits in the shadow for the next boundary.
  always_comb begin
    shadow_d     = shadow_q;
    shadowFull_d = shadowFull_q;
    active_d     = active_q;
    underrun_d   = 1'b0;
    if (accept) begin
      shadow_d     = i_sample;
      shadowFull_d = 1'b1;
    end
    if (wrap) begin
      if (shadowFull_q) begin
        active_d     = shadow_q;
        shadowFull_d = 1'b0;
      end else begin
        underrun_d = 1'b1;
      end
    end
    pwm_d = i_enable && (count < active_q);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow_q     <= '0;
      shadowFull_q <= 1'b0;
      active_q     <= '0;
      pwm_q        <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      shadowFull_q <= shadowFull_d;
      active_q     <= active_d;
      pwm_q        <= pwm_d;
      underrun_q   <= underrun_d;
    end
  end

  assign o_pwm      = pwm_q;
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_pwm_audio_dac.sv
// Directed bench for pwm_audio_dac: per-period duty, strobe and underrun counts
// checked against hand-computed values.
module tb_pwm_audio_dac;

  localparam int W = 9;
  localparam int PERIOD = 511;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_enable = 1'b1;
  logic [W-1:0] i_sample = '0;
  logic         i_sample_valid = 1'b0;
  logic         o_sample_ready;
  logic         o_pwm;
  logic         o_period_stb;
  logic         o_underrun;

  int vectorCount = 0;
  int miscompares = 0;

  pwm_audio_dac #(.WIDTH(W)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_enable      (i_enable),
    .i_sample      (i_sample),
    .i_sample_valid(i_sample_valid),
    .o_sample_ready(o_sample_ready),
    .o_pwm         (o_pwm),
    .o_period_stb  (o_period_stb),
    .o_underrun    (o_underrun)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectorCount++;
    if (observed != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One-cycle sample offer; called on a negedge, returns on the next negedge.
  task automatic applyStimulus(input logic [W-1:0] val);
    i_sample       = val;
    i_sample_valid = 1'b1;
    @(negedge i_clk);
    i_sample_valid = 1'b0;
  endtask

  // Called on the negedge of a strobe cycle; observes the following full period
  // and ends on the next strobe cycle. Optional sample offer at start (sendAt<0)
  // or at loop index sendAt (index 509 is the wrap cycle).
  task automatic measurePeriod(input logic doSend, input int sendAt, input logic [W-1:0] val,
                               output int highs, output int stbs, output int unders,
                               output int underPos);
    highs = 0; stbs = 0; unders = 0; underPos = -1;
    if (doSend && sendAt < 0) begin
      i_sample       = val;
      i_sample_valid = 1'b1;
    end
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge i_clk);
      highs += int'(o_pwm);
      stbs  += int'(o_period_stb);
      if (o_underrun) begin
        unders++;
        underPos = i;
      end
      if (doSend && sendAt < 0 && i == 0) i_sample_valid = 1'b0;
      if (doSend && sendAt >= 0 && i == sendAt) begin
        i_sample       = val;
        i_sample_valid = 1'b1;
      end
      if (doSend && sendAt >= 0 && i == sendAt + 1) i_sample_valid = 1'b0;
    end
  endtask

  // Bounded wait for the next strobe; n = negedges taken, 0 on timeout.
  task automatic waitStb(output int n, output int highs, output int unders);
    n = 0; highs = 0; unders = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge i_clk);
      highs  += int'(o_pwm);
      unders += int'(o_underrun);
      if (o_period_stb) begin
        n = i;
        break;
      end
    end
  endtask

  int n, highs, stbs, unders, upos, rdyHigh;

  initial begin
    // Reset state
    repeat (3) @(negedge i_clk);
    checkOutput("reset pwm", o_pwm, 0);
    checkOutput("reset stb", o_period_stb, 0);
    checkOutput("reset underrun", o_underrun, 0);
    checkOutput("reset ready", o_sample_ready, 1);

    // First sample 128 before the first wrap
    i_rst_n = 1'b1;
    applyStimulus(9'd128);
    checkOutput("t1 ready after accept", o_sample_ready, 0);
    waitStb(n, highs, unders);
    checkOutput("t1 first wrap delay", n, 510);
    checkOutput("t1 no underrun", unders, 0);
    checkOutput("t1 ready after load", o_sample_ready, 1);
    measurePeriod(1'b1, -1, 9'd0, highs, stbs, unders, upos);
    checkOutput("t1 highs 128", highs, 128);
    checkOutput("t1 one stb", stbs, 1);
    checkOutput("t1 underrun none", unders, 0);

    // Values 0, 511, then 200 with no further samples
    measurePeriod(1'b1, -1, 9'd511, highs, stbs, unders, upos);
    checkOutput("t2 highs 0", highs, 0);
    measurePeriod(1'b1, -1, 9'd200, highs, stbs, unders, upos);
    checkOutput("t2 highs 511", highs, 511);
    checkOutput("t2 stb", stbs, 1);
    measurePeriod(1'b0, -1, 9'd0, highs, stbs, unders, upos);
    checkOutput("t3 highs 200 a", highs, 200);
    checkOutput("t3 underrun a", unders, 1);
    checkOutput("t3 underrun pos a", upos, 510);
    measurePeriod(1'b0, -1, 9'd0, highs, stbs, unders, upos);
    checkOutput("t3 highs 200 b", highs, 200);
    checkOutput("t3 underrun b", unders, 1);
    checkOutput("t3 underrun pos b", upos, 510);

    // Back-pressure: 300 in shadow, 50 held against ready low
    applyStimulus(9'd300);
    i_sample       = 9'd50;
    i_sample_valid = 1'b1;
    rdyHigh = 0;
    waitStb(n, highs, unders);
    checkOutput("t4 wrap found", int'(n > 0), 1);
    checkOutput("t4 ready at wrap", o_sample_ready, 1);
    measurePeriod(1'b1, -1, 9'd50, highs, stbs, unders, upos);
    checkOutput("t4 highs 300", highs, 300);
    checkOutput("t4 no underrun", unders, 0);
    measurePeriod(1'b0, -1, 9'd0, highs, stbs, unders, upos);
    checkOutput("t4 highs 50", highs, 50);
    checkOutput("t4 underrun after", unders, 1);

    // Transfer of 77 on the exact wrap cycle, shadow empty
    measurePeriod(1'b1, 509, 9'd77, highs, stbs, unders, upos);
    checkOutput("t5 highs 50", highs, 50);
    checkOutput("t5 underrun pos", upos, 510);
    checkOutput("t5 ready low", o_sample_ready, 0);
    measurePeriod(1'b0, -1, 9'd0, highs, stbs, unders, upos);
    checkOutput("t5 old held", highs, 50);
    checkOutput("t5 no underrun", unders, 0);
    measurePeriod(1'b1, -1, 9'd400, highs, stbs, unders, upos);
    checkOutput("t5 highs 77", highs, 77);

    // Reset mid-period with active 400 and shadow full
    applyStimulus(9'd123);
    repeat (99) @(negedge i_clk);
    checkOutput("t6 pwm before reset", o_pwm, 1);
    checkOutput("t6 ready before reset", o_sample_ready, 0);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("t6 pwm in reset", o_pwm, 0);
    checkOutput("t6 ready in reset", o_sample_ready, 1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    waitStb(n, highs, unders);
    checkOutput("t6 wrap delay", n, 511);
    checkOutput("t6 highs after reset", highs, 0);
    checkOutput("t6 underrun", o_underrun, 1);
    measurePeriod(1'b1, -1, 9'd250, highs, stbs, unders, upos);
    checkOutput("t6 active cleared", highs, 0);
    checkOutput("t6 no underrun", unders, 0);

    // Disable for 1000 cycles; handshake still works
    i_enable = 1'b0;
    highs = 0; stbs = 0; unders = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge i_clk);
      highs  += int'(o_pwm);
      stbs   += int'(o_period_stb);
      unders += int'(o_underrun);
      if (i == 10) begin
        i_sample       = 9'd99;
        i_sample_valid = 1'b1;
      end
      if (i == 11) i_sample_valid = 1'b0;
    end
    checkOutput("t7 pwm low", highs, 0);
    checkOutput("t7 no stb", stbs, 0);
    checkOutput("t7 no underrun", unders, 0);
    checkOutput("t7 ready low", o_sample_ready, 0);
    i_enable = 1'b1;
    waitStb(n, highs, unders);
    checkOutput("t7 wrap delay", n, 511);
    checkOutput("t7 active kept", highs, 250);
    checkOutput("t7 load no underrun", unders, 0);
    measurePeriod(1'b0, -1, 9'd0, highs, stbs, unders, upos);
    checkOutput("t7 highs 99", highs, 99);
    checkOutput("t7 underrun pos", upos, 510);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
    $finish;
  end

endmodule
